// File: rtl/mem_boot_ctrl.sv
// Boot loader: streams words into data then instruction BRAM, then releases the core.
// Define BOOT_CHECKSUM_EN to add a trailing checksum word and an ERROR state.
module mem_boot_ctrl #(
  parameter int D_WORDS = 3,
  parameter int I_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [31:0] s_dat,
  output logic        s_ready,
  output logic [9:0]  d_w_addr,
  output logic [31:0] d_w_dat,
  output logic        d_w_enb,
  output logic [9:0]  i_w_addr,
  output logic [31:0] i_w_dat,
  output logic        i_w_enb,
  output logic        d_bram_init_done,
  output logic        pc_stall,
  output logic        i_r_enb,
  output logic        rd_enbl,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_I = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    CHECK  = 3'd4,
    ERROR  = 3'd5,
`endif
    RUN    = 3'd3
  } st_t;

`ifdef BOOT_CHECKSUM_EN
  localparam st_t AFTER_I = CHECK;
`else
  localparam st_t AFTER_I = RUN;
`endif

  localparam logic [31:0] D_LAST = 32'(D_WORDS - 1);
  localparam logic [31:0] I_LAST = 32'(I_WORDS - 1);

  st_t         state;
  st_t         state_nx;
  logic [31:0] idx;
  logic        hs;
  logic        in_chk;
  logic        in_load;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum;
  assign in_chk = (state == CHECK);
  assign error  = (state == ERROR);
`else
  assign in_chk = 1'b0;
  assign error  = 1'b0;
`endif

  assign in_load  = (state == LOAD_D) || (state == LOAD_I);
  assign s_ready  = in_load || in_chk;
  assign busy     = s_ready;
  assign hs       = s_valid && s_ready;
  assign done     = (state == RUN);
  assign i_r_enb  = done;
  assign rd_enbl  = done;
  assign pc_stall = !done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (start)
            state_nx = (D_WORDS > 0) ? LOAD_D
                     : (I_WORDS > 0) ? LOAD_I
                     : AFTER_I;
        LOAD_D:
          if (hs && idx == D_LAST)
            state_nx = (I_WORDS > 0) ? LOAD_I : AFTER_I;
        LOAD_I:
          if (hs && idx == I_LAST)
            state_nx = AFTER_I;
`ifdef BOOT_CHECKSUM_EN
        CHECK:
          if (hs)
            state_nx = (s_dat == sum) ? RUN : ERROR;
`endif
        default: state_nx = state;
      endcase
    end
  end

  // abort clears everything, including a write registered last cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx              <= '0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_bram_init_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum              <= '0;
`endif
    end else if (abort) begin
      idx              <= '0;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      d_bram_init_done <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum              <= '0;
`endif
    end else begin
      d_w_enb <= hs && (state == LOAD_D);
      i_w_enb <= hs && (state == LOAD_I);
      if (hs && state == LOAD_D) begin
        d_w_addr <= {idx[7:0], 2'b00};
        d_w_dat  <= s_dat;
      end
      if (hs && state == LOAD_I) begin
        i_w_addr <= {idx[7:0], 2'b00};
        i_w_dat  <= s_dat;
      end
      if (state == IDLE) begin
        idx <= '0;
      end else if (hs && in_load) begin
        idx <= (state_nx == state) ? idx + 32'd1 : '0;
      end
      if ((state == IDLE || state == LOAD_D) && state_nx != state &&
          state_nx != LOAD_D && state_nx != IDLE)
        d_bram_init_done <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      if (state == IDLE)
        sum <= '0;
      else if (hs && in_load)
        sum <= sum + s_dat;
`endif
    end
  end

endmodule

// File: tb/tb_mem_boot_ctrl.sv
// Bench for mem_boot_ctrl: word-count model checked every cycle plus directed scenarios.
// Works with and without BOOT_CHECKSUM_EN.
module tb_mem_boot_ctrl;

  localparam int D = 3;
  localparam int I = 8;
`ifdef BOOT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int TOT = D + I + CK;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_dat = '0;

  logic        s_ready, d_w_enb, i_w_enb, d_bram_init_done, pc_stall;
  logic        i_r_enb, rd_enbl, busy, done, error;
  logic [9:0]  d_w_addr, i_w_addr;
  logic [31:0] d_w_dat, i_w_dat;

  logic        w_s_ready, w_d_w_enb, w_i_w_enb, w_init, w_pc_stall;
  logic        w_i_r_enb, w_rd_enbl, w_busy, w_done, w_error;
  logic [9:0]  w_d_w_addr, w_i_w_addr;
  logic [31:0] w_d_w_dat, w_i_w_dat;

  logic        c_s_ready, c_d_w_enb, c_i_w_enb, c_init, c_pc_stall;
  logic        c_i_r_enb, c_rd_enbl, c_busy, c_done, c_error;
  logic [9:0]  c_d_w_addr, c_i_w_addr;
  logic [31:0] c_d_w_dat, c_i_w_dat;

  mem_boot_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_dat(s_dat), .s_ready(s_ready),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall),
    .i_r_enb(i_r_enb), .rd_enbl(rd_enbl),
    .busy(busy), .done(done), .error(error)
  );

  mem_boot_ctrl #(.D_WORDS(0), .I_WORDS(257)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_dat(s_dat), .s_ready(w_s_ready),
    .d_w_addr(w_d_w_addr), .d_w_dat(w_d_w_dat), .d_w_enb(w_d_w_enb),
    .i_w_addr(w_i_w_addr), .i_w_dat(w_i_w_dat), .i_w_enb(w_i_w_enb),
    .d_bram_init_done(w_init), .pc_stall(w_pc_stall),
    .i_r_enb(w_i_r_enb), .rd_enbl(w_rd_enbl),
    .busy(w_busy), .done(w_done), .error(w_error)
  );

  mem_boot_ctrl #(.D_WORDS(1), .I_WORDS(1)) u_ck (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_dat(s_dat), .s_ready(c_s_ready),
    .d_w_addr(c_d_w_addr), .d_w_dat(c_d_w_dat), .d_w_enb(c_d_w_enb),
    .i_w_addr(c_i_w_addr), .i_w_dat(c_i_w_dat), .i_w_enb(c_i_w_enb),
    .d_bram_init_done(c_init), .pc_stall(c_pc_stall),
    .i_r_enb(c_i_r_enb), .rd_enbl(c_rd_enbl),
    .busy(c_busy), .done(c_done), .error(c_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // model: progress is just the count of accepted words since start
  bit          m_act, m_bad;
  int          m_cnt;
  logic [31:0] m_sum;
  logic        m_de, m_ie;
  logic [9:0]  m_da, m_ia;
  logic [31:0] m_dd, m_id;

  logic [9:0]  dq_a[$];
  logic [9:0]  iq_a[$];
  logic [31:0] iq_d[$];
  logic [9:0]  wq_a[$];
  logic [31:0] wq_d[$];
  int          wd_cnt = 0;

  task automatic m_clear();
    m_act = 0; m_bad = 0; m_cnt = 0; m_sum = '0;
    m_de = 0; m_ie = 0; m_da = '0; m_ia = '0; m_dd = '0; m_id = '0;
  endtask

  initial begin
    bit ld, rn, er;
    m_clear();
    forever begin
      @(negedge clk);
      if (!rst) m_clear();
      ld = m_act && m_cnt < TOT;
      rn = m_act && m_cnt == TOT && !m_bad;
      er = m_act && m_bad;
      chk("ctl",
          64'({s_ready, busy, done, error, pc_stall, i_r_enb, rd_enbl,
               d_bram_init_done, d_w_enb, i_w_enb}),
          64'({ld, ld, rn, er, !rn, rn, rn,
               (m_act && m_cnt >= D), m_de, m_ie}));
      chk("d_port", 64'({d_w_addr, d_w_dat}), 64'({m_da, m_dd}));
      chk("i_port", 64'({i_w_addr, i_w_dat}), 64'({m_ia, m_id}));
      chk("one_hot", 64'(d_w_enb & i_w_enb), 64'd0);
      if (d_w_enb) dq_a.push_back(d_w_addr);
      if (i_w_enb) begin
        iq_a.push_back(i_w_addr);
        iq_d.push_back(i_w_dat);
      end
      if (w_i_w_enb) begin
        wq_a.push_back(w_i_w_addr);
        wq_d.push_back(w_i_w_dat);
      end
      if (w_d_w_enb) wd_cnt++;
      if (rst) begin
        if (abort) begin
          m_clear();
        end else begin
          m_de = 0;
          m_ie = 0;
          if (!m_act) begin
            if (start) begin
              m_act = 1; m_cnt = 0; m_sum = '0;
            end
          end else if (m_cnt < TOT && s_valid) begin
            if (m_cnt < D) begin
              m_de = 1;
              m_da = 10'((m_cnt * 4) % 1024);
              m_dd = s_dat;
              m_sum += s_dat;
            end else if (m_cnt < D + I) begin
              m_ie = 1;
              m_ia = 10'(((m_cnt - D) * 4) % 1024);
              m_id = s_dat;
              m_sum += s_dat;
            end else begin
              m_bad = (s_dat != m_sum);
            end
            m_cnt++;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    s_valid = 1'b1;
    s_dat = w;
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic kill();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  initial begin
    int bd, bi, bw, bwd;
    logic [31:0] s;
    #2;
    chk("rst_pcs", 64'(pc_stall), 64'd1);
    chk("rst_rdy", 64'({s_ready, done, busy}), 64'd0);
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();

    // contiguous load, valid held high
    bd = dq_a.size(); bi = iq_a.size();
    go();
    for (int k = 1; k <= 11; k++) send(32'(k));
`ifndef BOOT_CHECKSUM_EN
    chk("done_after_11", 64'({done, pc_stall}), 64'b10);
`endif
    send(32'h42);
    cyc(); cyc();
    chk("s1_d_cnt", 64'(dq_a.size() - bd), 64'd3);
    for (int k = 0; k < 3; k++)
      chk("s1_d_addr", 64'(dq_a[bd + k]), 64'(k * 4));
    chk("s1_i_cnt", 64'(iq_a.size() - bi), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("s1_i_addr", 64'(iq_a[bi + k]), 64'(k * 4));
      chk("s1_i_dat", 64'(iq_d[bi + k]), 64'(k + 4));
    end
    chk("s1_run", 64'({done, pc_stall, error}), 64'b100);
    go();
    chk("start_in_run", 64'(done), 64'd1);
    kill();
    chk("abort_idle", 64'({done, pc_stall, s_ready}), 64'b010);

    // valid toggling
    bd = dq_a.size(); bi = iq_a.size(); s = '0;
    go();
    for (int k = 1; k <= 11; k++) begin
      send(32'h100 + 32'(k));
      s += 32'h100 + 32'(k);
      s_dat = 32'hDEAD_BEEF;
      cyc();
    end
    send(s);
    cyc();
    chk("s2_d_cnt", 64'(dq_a.size() - bd), 64'd3);
    for (int k = 0; k < 3; k++)
      chk("s2_d_addr", 64'(dq_a[bd + k]), 64'(k * 4));
    chk("s2_i_cnt", 64'(iq_a.size() - bi), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("s2_i_addr", 64'(iq_a[bi + k]), 64'(k * 4));
      chk("s2_i_dat", 64'(iq_d[bi + k]), 64'(32'h104 + 32'(k)));
    end
    chk("s2_run", 64'(done), 64'd1);
    kill();

    // abort on the 2nd instruction handshake
    bi = iq_a.size();
    go();
    send(32'hA1); send(32'hA2); send(32'hA3); send(32'hB1);
    s_valid = 1'b1; s_dat = 32'hB2; abort = 1'b1;
    cyc();
    abort = 1'b0; s_valid = 1'b0;
    chk("ab_ienb", 64'({i_w_enb, s_ready}), 64'd0);
    cyc();
    chk("ab_i_cnt", 64'(iq_a.size() - bi), 64'd1);
    go();
    send(32'hAA);
    chk("re_d0", 64'({d_w_enb, d_w_addr, d_w_dat}), {1'b1, 10'h000, 32'hAA});
    send(32'hBB);
    chk("re_d1", 64'({d_w_enb, d_w_addr}), 64'({1'b1, 10'h004}));

    // reset mid-clock during LOAD_D
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctl", 64'({d_w_enb, s_ready, busy, d_bram_init_done, pc_stall}),
        64'b00001);
    chk("arst_d", 64'({d_w_addr, d_w_dat}), 64'd0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_idle", 64'(s_ready), 64'd0);
    go();
    send(32'h11);
    chk("rs_d0", 64'({d_w_enb, d_w_addr}), 64'({1'b1, 10'h000}));
    send(32'h22);
    chk("rs_d1", 64'({d_w_enb, d_w_addr}), 64'({1'b1, 10'h004}));
    kill();

    // checksum on the 1+1 instance
    go();
    send(32'hFFFF_FFFF); send(32'h2); send(32'h1);
    cyc();
    chk("ck_ok", 64'({c_done, c_error, c_pc_stall}), 64'b100);
    kill();
    go();
    send(32'hFFFF_FFFF); send(32'h2); send(32'h2);
    cyc();
    chk("ck_bad", 64'({c_done, c_error, c_pc_stall, c_s_ready}),
        CK ? 64'b0110 : 64'b1000);
    kill();

    // D_WORDS=0, I_WORDS=257 address wrap
    bw = wq_a.size(); bwd = wd_cnt;
    go();
    for (int k = 1; k <= 257; k++) send(32'(k));
    cyc(); cyc();
    chk("wr_cnt", 64'(wq_a.size() - bw), 64'd257);
    chk("wr_a256", 64'(wq_a[bw + 255]), 64'h3FC);
    chk("wr_a257", 64'(wq_a[bw + 256]), 64'h000);
    chk("wr_d257", 64'(wq_d[bw + 256]), 64'd257);
    chk("wr_no_d", 64'(wd_cnt - bwd), 64'd0);
    chk("wr_end", 64'({w_done, w_s_ready}), CK ? 64'b01 : 64'b10);
    kill();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
